// File: rtl/vend_controller.sv
// Vending machine controller: coin crediting, purchase checks, timed vend strobe
// and change return in 25-cent pulses. All outputs come straight from registers.
module vend_controller #(
  parameter int VEND_CYCLES = 4,
  parameter int COIN_PULSE  = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        coin25,
  input  logic        coin100,
  input  logic [3:0]  select,
  input  logic        buy,
  input  logic        refund,
  input  logic [3:0]  stock_empty,
  output logic [11:0] credit,
  output logic [3:0]  vend,
  output logic [3:0]  stock_dec,
  output logic        change25,
  output logic        busy,
  output logic        err
);

  localparam int VW = $clog2(VEND_CYCLES + 1);
  localparam int PW = $clog2(2 * COIN_PULSE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [VW-1:0] VEND_LAST       = VW'(VEND_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_HIGH_LAST = PW'(COIN_PULSE - 1);
  localparam logic [PW-1:0] PULSE_END       = PW'(2 * COIN_PULSE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST    = TW'(TIMEOUT - 1);
  localparam logic [12:0]   CREDIT_MAX      = 13'd4000;
  localparam logic [11:0]   COIN_STEP       = 12'd25;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_e;

  state_e          state_q;
  logic [11:0]     credit_q;
  logic [3:0]      vend_q;
  logic [3:0]      stockDec_q;
  logic            change25_q;
  logic            busy_q;
  logic            err_q;
  logic            coin25_q;
  logic            coin100_q;
  logic            buy_q;
  logic            refund_q;
  logic [VW-1:0]   vendCnt_q;
  logic [PW-1:0]   phaseCnt_q;
  logic [TW-1:0]   timeoutCnt_q;

  logic            coin25Edge;
  logic            coin100Edge;
  logic            buyEdge;
  logic            refundEdge;
  logic [12:0]     coinAdd;
  logic [12:0]     coinSum;
  logic            coinOver;
  logic            coinTake;
  logic [11:0]     credit_d;
  logic [11:0]     price;
  logic            selOneHot;
  logic            buyOk;

  // Purchases are judged against the credit including coins landing this cycle.
  always_comb begin
    coin25Edge  = coin25 & ~coin25_q;
    coin100Edge = coin100 & ~coin100_q;
    buyEdge     = buy & ~buy_q;
    refundEdge  = refund & ~refund_q;

    coinAdd = 13'd0;
    if (coin25Edge)  coinAdd = coinAdd + 13'd25;
    if (coin100Edge) coinAdd = coinAdd + 13'd100;
    coinSum  = {1'b0, credit_q} + coinAdd;
    coinOver = (coinAdd != 13'd0) && (coinSum > CREDIT_MAX);
    coinTake = (coinAdd != 13'd0) && !coinOver;
    credit_d = coinTake ? coinSum[11:0] : credit_q;

    price     = 12'd0;
    selOneHot = 1'b1;
    case (select)
      4'b0001: price = 12'd25;
      4'b0010: price = 12'd75;
      4'b0100: price = 12'd150;
      4'b1000: price = 12'd200;
      default: selOneHot = 1'b0;
    endcase
    buyOk = selOneHot && (credit_d >= price) && ((stock_empty & select) == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      vend_q       <= '0;
      stockDec_q   <= '0;
      change25_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      coin25_q     <= 1'b1;
      coin100_q    <= 1'b1;
      buy_q        <= 1'b1;
      refund_q     <= 1'b1;
      vendCnt_q    <= '0;
      phaseCnt_q   <= '0;
      timeoutCnt_q <= '0;
    end else begin
      coin25_q   <= coin25;
      coin100_q  <= coin100;
      buy_q      <= buy;
      refund_q   <= refund;
      err_q      <= 1'b0;
      stockDec_q <= '0;

      case (state_q)
        S_IDLE, S_CREDIT: begin
          credit_q <= credit_d;
          if (coinOver || (buyEdge && !buyOk)) err_q <= 1'b1;
          if (coinTake) timeoutCnt_q <= '0;
          else if (state_q == S_CREDIT) timeoutCnt_q <= timeoutCnt_q + 1'b1;

          if (buyEdge && buyOk) begin
            credit_q     <= credit_d - price;
            vend_q       <= select;
            stockDec_q   <= select;
            vendCnt_q    <= '0;
            busy_q       <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= S_VEND;
          end else if ((state_q == S_CREDIT) &&
                       (refundEdge || (!coinTake && timeoutCnt_q == TIMEOUT_LAST))) begin
            credit_q   <= credit_d - COIN_STEP;
            change25_q <= 1'b1;
            phaseCnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_CHANGE;
          end else if ((state_q == S_IDLE) && (credit_q != 12'd0)) begin
            timeoutCnt_q <= '0;
            state_q      <= S_CREDIT;
          end
        end

        S_VEND: begin
          if (vendCnt_q == VEND_LAST) begin
            vend_q <= '0;
            if (credit_q != 12'd0) begin
              credit_q   <= credit_q - COIN_STEP;
              change25_q <= 1'b1;
              phaseCnt_q <= '0;
              state_q    <= S_CHANGE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            vendCnt_q <= vendCnt_q + 1'b1;
          end
        end

        // Each pulse is COIN_PULSE high then COIN_PULSE low; credit drops as it rises.
        S_CHANGE: begin
          if (phaseCnt_q == PULSE_END) begin
            if (credit_q == 12'd0) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              credit_q   <= credit_q - COIN_STEP;
              change25_q <= 1'b1;
              phaseCnt_q <= '0;
            end
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
            if (phaseCnt_q == PULSE_HIGH_LAST) change25_q <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign credit    = credit_q;
  assign vend      = vend_q;
  assign stock_dec = stockDec_q;
  assign change25  = change25_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter VEND_CYCLES, default 4, SHALL set the number of cycles a vend output is held high.
REQ-003 Parameter COIN_PULSE, default 2, SHALL set the high time and the low time, in cycles, of each change25 pulse.
REQ-004 Parameter TIMEOUT, default 1000, SHALL set the number of idle cycles in CREDIT before an automatic refund.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 coin25  in  1  level input; each rising edge deposits 25.
REQ-008 coin100  in  1  level input; each rising edge deposits 100.
REQ-009 select  in  4  one-hot product select; prices are bit0=25, bit1=75, bit2=150, bit3=200.
REQ-010 buy  in  1  level input; a rising edge requests a purchase.
REQ-011 refund  in  1  level input; a rising edge requests return of all credit.
REQ-012 stock_empty  in  4  per-product empty flags from the stock datapath.
REQ-013 credit  out  12  current credit, binary cents.
REQ-014 vend  out  4  one-hot dispense strobe.
REQ-015 stock_dec  out  4  one-cycle stock decrement pulse to the stock datapath.
REQ-016 change25  out  1  change-return pulse; each pulse returns 25.
REQ-017 busy  out  1  high in VEND or CHANGE.
REQ-018 err  out  1  one-cycle rejection pulse.

Function
REQ-019 Edge detection SHALL register each of coin25, coin100, buy and refund, and SHALL detect a rising edge when the registered value is 0 and the current value is 1.
REQ-020 The FSM SHALL have four states: IDLE (credit==0), CREDIT (credit>0), VEND, and CHANGE.
REQ-021 Coin edges SHALL be credited only in IDLE or CREDIT, and SHALL be ignored with no err pulse in VEND or CHANGE.
REQ-022 Simultaneous coin25 and coin100 edges SHALL both be credited (+125) in the same cycle.
REQ-023 If the post-add credit would exceed 4000, all coin edges in that cycle SHALL be discarded, credit SHALL be unchanged, and err SHALL pulse.
REQ-024 IDLE SHALL move to CREDIT on the cycle after credit becomes nonzero.
REQ-025 A buy edge in IDLE or CREDIT SHALL be evaluated against credit plus any coins accepted in the same cycle.
REQ-026 A buy edge SHALL be rejected with a one-cycle err pulse, and credit and state unchanged, if select is not one-hot, if credit is below the price, or if stock_empty of the selected product is 1.
REQ-027 On an accepted buy, the next cycle SHALL enter VEND with credit reduced by the price, and select SHALL be latched at the buy edge.
REQ-028 In VEND, vend[i] SHALL be high for exactly VEND_CYCLES cycles, and stock_dec[i] SHALL be high only in the first VEND cycle.
REQ-029 On leaving VEND, the FSM SHALL go to CHANGE if credit>0, else to IDLE.
REQ-030 A refund edge in CREDIT SHALL enter CHANGE on the next cycle; a refund edge in IDLE, VEND or CHANGE SHALL be ignored.
REQ-031 The timeout counter SHALL clear on entering CREDIT and on any accepted coin or buy edge.
REQ-032 When the timeout counter reaches TIMEOUT cycles in CREDIT, the FSM SHALL enter CHANGE.
REQ-033 In CHANGE, change25 SHALL go high for COIN_PULSE cycles then low for COIN_PULSE cycles, repeating.
REQ-034 Credit SHALL decrement by 25 in the first high cycle of each change25 pulse.
REQ-035 The FSM SHALL go to IDLE after the low phase that follows the pulse bringing credit to 0.
REQ-036 Buy and refund edges during VEND or CHANGE SHALL be ignored, with no err pulse.
REQ-037 Credit SHALL always be a multiple of 25, and arithmetic SHALL be unsigned 12-bit with no wrap.
REQ-038 All outputs SHALL be registered.

Reset
REQ-039 While rst_n==0 at a clock edge, the state SHALL become IDLE and credit, vend, stock_dec, change25, busy, err and the timeout counter SHALL become 0.
REQ-040 While rst_n==0 at a clock edge, all edge-detect registers SHALL become 1, so that inputs held high across reset release are not counted.
REQ-041 Reset asserted mid-VEND or mid-CHANGE SHALL abort on that edge and discard remaining credit, with no further pulses.

Verification
REQ-042 Scenario 1: coin100 edge, coin25 edge, select=0010, buy edge -> credit=125, then 50; vend[1] high 4 cycles; stock_dec[1] single pulse; two change25 pulses; IDLE with credit=0.
REQ-043 Scenario 2: credit=50, select=0100, buy edge -> err single pulse; credit=50; state CREDIT.
REQ-044 Scenario 3: stock_empty=0001, credit=100, select=0001, buy edge -> err pulse, no vend; select=0011, buy edge -> err pulse.
REQ-045 Scenario 4: coin25 edge, then no activity for TIMEOUT cycles -> CHANGE; exactly one change25 pulse; IDLE.
REQ-046 Scenario 5: coin25 and coin100 rise in the same cycle -> credit=125; credit=3950, coin100 edge -> err pulse, credit=3950.
REQ-047 Scenario 6: rst_n low during the 2nd VEND cycle -> vend=0 and credit=0 after that edge; coin25 held high through reset release -> no credit.
